// File: rtl/alu_issue_stage.sv
// RV32I decode-to-execute issue stage: decodes OP / OP-IMM / LUI into an ALU
// opcode plus operands and buffers issued bundles in a 2-entry skid register.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALU_op,
  output logic [31:0]      alu_data1,
  output logic [31:0]      alu_data2,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_count,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } bundle_t;

  localparam logic [1:0] EMPTY     = 2'd0;
  localparam logic [1:0] FULL      = 2'd1;
  localparam logic [1:0] SKID_FULL = 2'd2;

  logic [1:0]       state_r, state_nxt_s;
  logic             in_ready_r, out_valid_r;
  bundle_t          main_r, skid_r, dec_s;
  logic [CNT_W-1:0] issued_cnt_r, illegal_cnt_r;
  logic             in_fire_s, out_fire_s;
  logic             main_ld_dec_s, main_ld_skid_s, skid_ld_s;
  logic [3:0]       op_s;
  logic [31:0]      d1_s, d2_s;
  logic             legal_s, f7_zero_s, f7_alt_s;

  assign f7_zero_s  = (instr[31:25] == 7'b0000000);
  assign f7_alt_s   = (instr[31:25] == 7'b0100000);
  assign in_fire_s  = in_valid & in_ready_r & ~flush;
  assign out_fire_s = out_valid_r & out_ready;

  // Decode the offered instruction; illegal encodings are zeroed below.
  always_comb begin
    op_s    = 4'd0;
    d1_s    = 32'd0;
    d2_s    = 32'd0;
    legal_s = 1'b0;
    case (instr[6:0])
      7'b0110011: begin
        d1_s = rs1_data;
        d2_s = rs2_data;
        case (instr[14:12])
          3'b000: begin legal_s = f7_zero_s | f7_alt_s; op_s = f7_alt_s ? 4'd1 : 4'd0; end
          3'b001: begin legal_s = f7_zero_s; op_s = 4'd2; end
          3'b010: begin legal_s = f7_zero_s; op_s = 4'd3; end
          3'b011: begin legal_s = f7_zero_s; op_s = 4'd4; end
          3'b100: begin legal_s = f7_zero_s; op_s = 4'd5; end
          3'b101: begin legal_s = f7_zero_s | f7_alt_s; op_s = f7_alt_s ? 4'd7 : 4'd6; end
          3'b110: begin legal_s = f7_zero_s; op_s = 4'd8; end
          3'b111: begin legal_s = f7_zero_s; op_s = 4'd9; end
          default: begin legal_s = 1'b0; op_s = 4'd0; end
        endcase
      end
      7'b0010011: begin
        d1_s = rs1_data;
        d2_s = {{20{instr[31]}}, instr[31:20]};
        case (instr[14:12])
          3'b000: begin legal_s = 1'b1; op_s = 4'd0; end
          3'b001: begin legal_s = f7_zero_s; op_s = 4'd2; d2_s = {27'd0, instr[24:20]}; end
          3'b010: begin legal_s = 1'b1; op_s = 4'd3; end
          3'b011: begin legal_s = 1'b1; op_s = 4'd4; end
          3'b100: begin legal_s = 1'b1; op_s = 4'd5; end
          3'b101: begin
            legal_s = f7_zero_s | f7_alt_s;
            op_s    = f7_alt_s ? 4'd7 : 4'd6;
            d2_s    = {27'd0, instr[24:20]};
          end
          3'b110: begin legal_s = 1'b1; op_s = 4'd8; end
          3'b111: begin legal_s = 1'b1; op_s = 4'd9; end
          default: begin legal_s = 1'b0; op_s = 4'd0; end
        endcase
      end
      7'b0110111: begin
        legal_s = 1'b1;
        op_s    = 4'd10;
        d1_s    = 32'd0;
        d2_s    = {instr[31:12], 12'd0};
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
    if (legal_s) begin
      dec_s = '{op: op_s, d1: d1_s, d2: d2_s, rd: instr[11:7], we: 1'b1, ill: 1'b0};
    end else begin
      dec_s = '{op: 4'd0, d1: 32'd0, d2: 32'd0, rd: instr[11:7], we: 1'b0, ill: 1'b1};
    end
  end

  // Buffer control: choose next state and which register captures what.
  always_comb begin
    state_nxt_s    = state_r;
    main_ld_dec_s  = 1'b0;
    main_ld_skid_s = 1'b0;
    skid_ld_s      = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_ld_dec_s = 1'b1;
            state_nxt_s   = FULL;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        FULL: begin
          if (out_ready && in_fire_s) begin
            main_ld_dec_s = 1'b1;
            state_nxt_s   = FULL;
          end else if (out_ready) begin
            state_nxt_s = EMPTY;
          end else if (in_fire_s) begin
            skid_ld_s   = 1'b1;
            state_nxt_s = SKID_FULL;
          end else begin
            state_nxt_s = FULL;
          end
        end
        SKID_FULL: begin
          if (out_ready) begin
            main_ld_skid_s = 1'b1;
            state_nxt_s    = FULL;
          end else begin
            state_nxt_s = SKID_FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // State, buffer registers, registered handshakes and transfer counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= EMPTY;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      main_r        <= '0;
      skid_r        <= '0;
      issued_cnt_r  <= '0;
      illegal_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != SKID_FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
      if (main_ld_dec_s) begin
        main_r <= dec_s;
      end else if (main_ld_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (skid_ld_s) begin
        skid_r <= dec_s;
      end else begin
        skid_r <= skid_r;
      end
      // A transfer coinciding with a flush still counts.
      if (out_fire_s) begin
        issued_cnt_r <= issued_cnt_r + CNT_W'(1);
        if (main_r.ill) begin
          illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
        end else begin
          illegal_cnt_r <= illegal_cnt_r;
        end
      end else begin
        issued_cnt_r  <= issued_cnt_r;
        illegal_cnt_r <= illegal_cnt_r;
      end
    end
  end

  assign in_ready      = in_ready_r;
  assign out_valid     = out_valid_r;
  assign ALU_op        = main_r.op;
  assign alu_data1     = main_r.d1;
  assign alu_data2     = main_r.d2;
  assign rd_addr       = main_r.rd;
  assign rd_we         = main_r.we;
  assign illegal       = main_r.ill;
  assign issued_count  = issued_cnt_r;
  assign illegal_count = illegal_cnt_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: constant vector table, directed handshake
// sequences and randomized traffic checked against a queue-based model.
module tb_alu_issue_stage;
  localparam int CNT_W = 4;

  logic clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, rs1_data, rs2_data, alu_data1, alu_data2;
  logic [3:0] ALU_op;
  logic [4:0] rd_addr;
  logic rd_we, illegal;
  logic [CNT_W-1:0] issued_count, illegal_count;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_op(ALU_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal), .issued_count(issued_count),
    .illegal_count(illegal_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [31:0] d1; logic [31:0] d2; logic [4:0] rd; logic we; logic ill;
  } bundle_t;

  typedef struct {
    logic [31:0] instr; logic [31:0] a; logic [31:0] b;
    logic [3:0] op; logic [31:0] d1; logic [31:0] d2; logic [4:0] rd; logic we; logic ill;
  } vec_t;

  localparam logic [3:0] BASE [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  bundle_t q[$];
  logic m_in_ready;
  logic [CNT_W-1:0] m_issued, m_illegal, saved_iss, saved_ill;
  int checks = 0, errors = 0;
  vec_t vecs [10];

  // Reference decode straight from the instruction-set rules.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    bundle_t r;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    r.op = 4'd0; r.d1 = 32'd0; r.d2 = 32'd0; r.rd = w[11:7]; r.we = 1'b0; r.ill = 1'b1;
    if (w[6:0] == 7'h33) begin
      if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        r.op = BASE[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
        r.d1 = a; r.d2 = b; r.we = 1'b1; r.ill = 1'b0;
      end
    end else if (w[6:0] == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
          r.op = BASE[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
          r.d1 = a; r.d2 = 32'(w[24:20]); r.we = 1'b1; r.ill = 1'b0;
        end
      end else begin
        r.op = BASE[f3]; r.d1 = a; r.d2 = 32'($signed(w[31:20]));
        r.we = 1'b1; r.ill = 1'b0;
      end
    end else if (w[6:0] == 7'h37) begin
      r.op = 4'd10; r.d2 = {w[31:12], 12'h000}; r.we = 1'b1; r.ill = 1'b0;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: advance the model at the edge, then compare at the falling edge.
  task automatic tick();
    logic ofire, ifire;
    @(posedge clk);
    if (reset) begin
      q.delete(); m_issued = '0; m_illegal = '0; m_in_ready = 1'b0;
    end else begin
      ofire = (q.size() > 0) && out_ready;
      ifire = in_valid && m_in_ready && !flush;
      if (ofire) begin
        m_issued = m_issued + CNT_W'(1);
        if (q[0].ill) m_illegal = m_illegal + CNT_W'(1);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (ifire) q.push_back(ref_decode(instr, rs1_data, rs2_data));
      m_in_ready = (q.size() < 2);
    end
    @(negedge clk);
    cmp("out_valid", 32'(out_valid), 32'(q.size() > 0));
    cmp("in_ready", 32'(in_ready), 32'(m_in_ready));
    cmp("issued_count", 32'(issued_count), 32'(m_issued));
    cmp("illegal_count", 32'(illegal_count), 32'(m_illegal));
    if (q.size() > 0) begin
      cmp("ALU_op", 32'(ALU_op), 32'(q[0].op));
      cmp("alu_data1", alu_data1, q[0].d1);
      cmp("alu_data2", alu_data2, q[0].d2);
      cmp("rd_addr", 32'(rd_addr), 32'(q[0].rd));
      cmp("rd_we", 32'(rd_we), 32'(q[0].we));
      cmp("illegal", 32'(illegal), 32'(q[0].ill));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; instr = w; rs1_data = a; rs2_data = b;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [6:0] opc;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0, 1: opc = 7'h33;
      2: opc = 7'h13;
      3: opc = 7'h37;
      default: opc = r[6:0];
    endcase
    return {f7, r[24:7], opc};
  endfunction

  initial begin
    vecs[0] = '{32'h002081B3, 32'd5, 32'd7, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    vecs[1] = '{32'h4030D093, 32'h80000000, 32'd9, 4'd7, 32'h80000000, 32'd3, 5'd1, 1'b1, 1'b0};
    vecs[2] = '{32'hFFF00093, 32'h10, 32'd9, 4'd0, 32'h10, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0};
    vecs[3] = '{32'h0000007F, 32'h1234, 32'h5678, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
    vecs[4] = '{32'h123450B7, 32'hAAAA, 32'hBBBB, 4'd10, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0};
    vecs[5] = '{32'h40208133, 32'd20, 32'd3, 4'd1, 32'd20, 32'd3, 5'd2, 1'b1, 1'b0};
    vecs[6] = '{32'h4020C133, 32'd1, 32'd2, 4'd0, 32'd0, 32'd0, 5'd2, 1'b0, 1'b1};
    vecs[7] = '{32'h00503193, 32'd77, 32'd1, 4'd4, 32'd77, 32'd5, 5'd3, 1'b1, 1'b0};
    vecs[8] = '{32'h40109093, 32'd4, 32'd4, 4'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1};
    vecs[9] = '{32'h0020F1B3, 32'hF0F0, 32'h0FF0, 4'd9, 32'hF0F0, 32'h0FF0, 5'd3, 1'b1, 1'b0};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    q.delete(); m_issued = '0; m_illegal = '0; m_in_ready = 1'b0;
    tick();
    cmp("rst_in_ready", 32'(in_ready), 32'd0);
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_ALU_op", 32'(ALU_op), 32'd0);
    cmp("rst_data1", alu_data1, 32'd0);
    cmp("rst_data2", alu_data2, 32'd0);
    cmp("rst_rd", 32'({rd_addr, rd_we, illegal}), 32'd0);
    cmp("rst_counts", 32'({issued_count, illegal_count}), 32'd0);
    reset = 1'b0;
    tick();
    cmp("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table: each vector issued alone with the consumer ready.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].a, vecs[i].b);
      tick();
      cmp($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      cmp($sformatf("vec%0d_op", i), 32'(ALU_op), 32'(vecs[i].op));
      cmp($sformatf("vec%0d_d1", i), alu_data1, vecs[i].d1);
      cmp($sformatf("vec%0d_d2", i), alu_data2, vecs[i].d2);
      cmp($sformatf("vec%0d_rd", i), 32'(rd_addr), 32'(vecs[i].rd));
      cmp($sformatf("vec%0d_we", i), 32'(rd_we), 32'(vecs[i].we));
      cmp($sformatf("vec%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      tick();
      if (i == 0) cmp("first_issued_count", 32'(issued_count), 32'd1);
      if (i == 3) cmp("first_illegal_count", 32'(illegal_count), 32'd1);
    end

    // Backpressure: A to MAIN, B to SKID, C held off until space frees.
    out_ready = 1'b0;
    drive(1'b1, 32'h00000033 | (32'd1 << 7), 32'hA, 32'h1);
    tick();
    drive(1'b1, 32'h00000033 | (32'd2 << 7), 32'hB, 32'h2);
    tick();
    cmp("bp_in_ready_low", 32'(in_ready), 32'd0);
    cmp("bp_rd_A", 32'(rd_addr), 32'd1);
    drive(1'b1, 32'h00000033 | (32'd3 << 7), 32'hC, 32'h3);
    tick();
    tick();
    cmp("bp_hold_A", alu_data1, 32'hA);
    out_ready = 1'b1;
    tick();
    cmp("bp_rd_B", 32'(rd_addr), 32'd2);
    tick();
    cmp("bp_rd_C", 32'(rd_addr), 32'd3);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    cmp("bp_drained", 32'(out_valid), 32'd0);

    // Flush while SKID_FULL with a bundle offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd1, 32'd1);
    tick();
    tick();
    saved_iss = issued_count; saved_ill = illegal_count;
    drive(1'b1, 32'h00000033 | (32'd9 << 7), 32'd9, 32'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp("flush_out_valid", 32'(out_valid), 32'd0);
    cmp("flush_in_ready", 32'(in_ready), 32'd1);
    cmp("flush_issued", 32'(issued_count), 32'(saved_iss));
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    cmp("flush_no_issue", 32'(issued_count), 32'(saved_iss));
    cmp("flush_no_illegal", 32'(illegal_count), 32'(saved_ill));

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom);
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 39) == 0;
      reset = $urandom_range(0, 199) == 0;
      tick();
    end
    flush = 1'b0;

    // Counter wrap: 17 transfers on a 4-bit counter.
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    drive(1'b1, 32'h123450B7, 32'd0, 32'd0);
    tick();
    cmp("lui_op", 32'(ALU_op), 32'd10);
    cmp("lui_d2", alu_data2, 32'h12345000);
    for (int k = 1; k < 17; k++) begin
      drive(1'b1, rand_instr(), $urandom, $urandom);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    cmp("wrap_issued", 32'(issued_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
